// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle RV32I control
package riscv_ctrl_pkg;

  // Sequencer state encodings (4-bit state register)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  // Opcodes, Instr[6:0]
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp, shared with the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instrdec.sv
// rtl/instrdec.sv - combinational opcode to immediate-format decoder
module instrdec
  import riscv_ctrl_pkg::*;
#(
  parameter int OPW = 7
) (
  input  logic [OPW-1:0] op,
  output logic [1:0]     ImmSrc
);

  // Immediate format follows the opcode directly; unknown opcodes fall back to I-type
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I main sequencer; MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds HALT state and Illegal flag
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = S_FETCH,
  parameter int         OPW         = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           AdrSrc,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic [1:0]     ResultSrc,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     ImmSrc,
  output logic           RegWrite
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic           Illegal
`endif
);

  logic [3:0] state_q, state_d;
  logic       pc_update, branch, ir_write, mem_write, reg_write;

  // State register; reset abandons whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Next-state logic; fetch and memory states stall until MemReady
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; anything not named for a state stays 0
  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write enables are suppressed while reset is held
  assign PCWrite  = ~reset & (pc_update | (branch & Zero));
  assign IRWrite  = ~reset & ir_write;
  assign MemWrite = ~reset & mem_write;
  assign RegWrite = ~reset & reg_write;

  instrdec #(.OPW(OPW)) u_instrdec (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag raised on the edge that enters HALT, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)                 illegal_q <= 1'b0;
    else if (state_d == S_HALT) illegal_q <= 1'b1;
  end

  assign Illegal = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite)
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    .Illegal   (Illegal)
`endif
  );

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Instruction phases of the reference model
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
  localparam int P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_BEQ = 9;
  localparam int P_JAL = 10, P_HALT = 11;

  int script[$];
  bit known = 1'b0;
  bit ill_m = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  wire [14:0] dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                         ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected output vector for a phase: {P,A,M,I,R,rs,sa,sb,aop,imm}
  function automatic logic [14:0] expect_of(int ph, logic rst, logic mr, logic z, logic [6:0] o);
    logic p, a, m, i, r;
    logic [1:0] rs, sa, sb, ao;
    p = 0; a = 0; m = 0; i = 0; r = 0; rs = 0; sa = 0; sb = 0; ao = 0;
    case (ph)
      P_FETCH:    begin sb = 2'b10; rs = 2'b10; i = mr; p = mr; end
      P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD:  a = 1;
      P_MEMWB:    begin rs = 2'b01; r = 1; end
      P_MEMWRITE: begin a = 1; m = 1; end
      P_EXR:      begin sa = 2'b10; ao = 2'b10; end
      P_EXI:      begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      P_ALUWB:    r = 1;
      P_BEQ:      begin sa = 2'b10; ao = 2'b01; p = z; end
      P_JAL:      begin sa = 2'b01; sb = 2'b10; p = 1; end
      default:    ;
    endcase
    if (rst) begin p = 0; m = 0; i = 0; r = 0; end
    return {p, a, m, i, r, rs, sa, sb, ao, imm_of(o)};
  endfunction

  // Advance the instruction script on a rising edge
  task automatic model_step();
    int cur;
    if (reset) begin
      script = {P_FETCH};
      known = 1'b1;
      ill_m = 1'b0;
      return;
    end
    if (!known) return;
    cur = script[0];
    if (cur == P_HALT) return;
    if ((cur == P_FETCH || cur == P_MEMREAD || cur == P_MEMWRITE) && !MemReady) return;
    void'(script.pop_front());
    if (cur == P_FETCH) script.push_back(P_DECODE);
    if (cur == P_DECODE) begin
      case (op)
        LW:      begin script.push_back(P_MEMADR); script.push_back(P_MEMREAD); script.push_back(P_MEMWB); end
        SW:      begin script.push_back(P_MEMADR); script.push_back(P_MEMWRITE); end
        RT:      begin script.push_back(P_EXR); script.push_back(P_ALUWB); end
        IT:      begin script.push_back(P_EXI); script.push_back(P_ALUWB); end
        BQ:      script.push_back(P_BEQ);
        JL:      begin script.push_back(P_JAL); script.push_back(P_ALUWB); end
        default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          script.push_back(P_HALT);
          ill_m = 1'b1;
`endif
        end
      endcase
    end
    if (script.size() == 0) script.push_back(P_FETCH);
  endtask

  // Every cycle with a known model state, compare outputs against the model
  always @(negedge clk) begin
    logic [14:0] exp_v;
    #2;
    if (known) begin
      exp_v = expect_of(script[0], reset, MemReady, Zero, op);
      vectors++;
      if (dut_vec !== exp_v) begin
        miscompares++;
        $display("FAIL model_outputs t=%0t got %b want %b", $time, dut_vec, exp_v);
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      vectors++;
      if (Illegal !== ill_m) begin
        miscompares++;
        $display("FAIL model_illegal t=%0t got %b want %b", $time, Illegal, ill_m);
      end
`endif
    end
  end

  // One clock: drive inputs, optionally check a literal expectation, advance model
  task automatic cyc(input logic rst, input logic [6:0] o, input logic mr, input logic z,
                     input bit chk, input logic [14:0] exp_v, input logic ill);
    @(negedge clk);
    reset = rst; op = o; MemReady = mr; Zero = z;
    #3;
    if (chk) begin
      vectors++;
      if (dut_vec !== exp_v) begin
        miscompares++;
        $display("FAIL literal t=%0t got %b want %b", $time, dut_vec, exp_v);
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      vectors++;
      if (Illegal !== ill) begin
        miscompares++;
        $display("FAIL literal_illegal t=%0t got %b want %b", $time, Illegal, ill);
      end
`endif
    end
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [6:0] rop;
    logic       rrst;
    // R-type after two reset cycles
    cyc(1, RT, 1, 0, 0, 15'b0, 0);
    cyc(1, RT, 1, 0, 1, 15'b0_0_0_0_0_10_00_10_00_00, 0);
    cyc(0, RT, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_00, 0);
    cyc(0, RT, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_00, 0);
    cyc(0, RT, 1, 0, 1, 15'b0_0_0_0_0_00_10_00_10_00, 0);
    cyc(0, RT, 1, 0, 1, 15'b0_0_0_0_1_00_00_00_00_00, 0);
    // lw with three MemReady-low cycles in MEMREAD: 8 cycles total
    cyc(0, LW, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_00, 0);
    cyc(0, LW, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_00, 0);
    cyc(0, LW, 1, 0, 1, 15'b0_0_0_0_0_00_10_01_00_00, 0);
    cyc(0, LW, 0, 0, 1, 15'b0_1_0_0_0_00_00_00_00_00, 0);
    cyc(0, LW, 0, 0, 1, 15'b0_1_0_0_0_00_00_00_00_00, 0);
    cyc(0, LW, 0, 0, 1, 15'b0_1_0_0_0_00_00_00_00_00, 0);
    cyc(0, LW, 1, 0, 1, 15'b0_1_0_0_0_00_00_00_00_00, 0);
    cyc(0, LW, 1, 0, 1, 15'b0_0_0_0_1_01_00_00_00_00, 0);
    // beq taken then not taken
    cyc(0, BQ, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_10, 0);
    cyc(0, BQ, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_10, 0);
    cyc(0, BQ, 1, 1, 1, 15'b1_0_0_0_0_00_10_00_01_10, 0);
    cyc(0, BQ, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_10, 0);
    cyc(0, BQ, 1, 1, 1, 15'b0_0_0_0_0_00_01_01_00_10, 0);
    cyc(0, BQ, 1, 0, 1, 15'b0_0_0_0_0_00_10_00_01_10, 0);
    // sw with one wait cycle
    cyc(0, SW, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_01, 0);
    cyc(0, SW, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_01, 0);
    cyc(0, SW, 1, 0, 1, 15'b0_0_0_0_0_00_10_01_00_01, 0);
    cyc(0, SW, 0, 0, 1, 15'b0_1_1_0_0_00_00_00_00_01, 0);
    cyc(0, SW, 1, 0, 1, 15'b0_1_1_0_0_00_00_00_00_01, 0);
    // jal
    cyc(0, JL, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_11, 0);
    cyc(0, JL, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_11, 0);
    cyc(0, JL, 1, 0, 1, 15'b1_0_0_0_0_00_01_10_00_11, 0);
    cyc(0, JL, 1, 0, 1, 15'b0_0_0_0_1_00_00_00_00_11, 0);
    // lw with reset asserted in MEMWB
    cyc(0, LW, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_00, 0);
    cyc(0, LW, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_00, 0);
    cyc(0, LW, 1, 0, 1, 15'b0_0_0_0_0_00_10_01_00_00, 0);
    cyc(0, LW, 1, 0, 1, 15'b0_1_0_0_0_00_00_00_00_00, 0);
    cyc(1, LW, 1, 0, 1, 15'b0_0_0_0_0_01_00_00_00_00, 0);
    // illegal opcode
    cyc(0, BAD, 0, 0, 1, 15'b0_0_0_0_0_10_00_10_00_00, 0);
    cyc(0, BAD, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_00, 0);
    cyc(0, BAD, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_00, 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    cyc(0, BAD, 1, 0, 1, 15'b0, 1);
    cyc(0, LW, 1, 0, 1, 15'b0, 1);
`else
    cyc(0, BAD, 1, 0, 1, 15'b1_0_0_1_0_10_00_10_00_00, 0);
    cyc(0, BAD, 1, 0, 1, 15'b0_0_0_0_0_00_01_01_00_00, 0);
`endif
    // Randomized traffic; opcode only changes while fetching
    rop = RT;
    for (int k = 0; k < 3000; k++) begin
      rrst = (k == 0) || ($urandom_range(0, 59) == 0);
      if (script[0] == P_FETCH) begin
        case ($urandom_range(0, 7))
          0: rop = LW;
          1: rop = SW;
          2: rop = RT;
          3: rop = IT;
          4: rop = BQ;
          5: rop = JL;
          6: rop = BAD;
          default: rop = 7'($urandom);
        endcase
      end
      cyc(rrst, rop, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 0, 15'b0, 0);
    end
    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
